// File: rtl/mem_stage_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_sram_ctrl
// Description : Pipeline MEM stage. It runs loads and stores against an
//               external fixed-latency SRAM and holds the front of the
//               pipeline with freeze while an access is in flight. The
//               MEM->WB pipeline register is owned here.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_sram_ctrl #(
    parameter int WAIT_CYCLES = 4,     // SRAM strobe hold time per access, >= 1
    parameter int ADDR_BASE   = 1024,  // byte address of SRAM word 0
    parameter int MEM_AW      = 17     // SRAM word-address width
) (
    input  logic              clk,
    input  logic              rst,
    // EXE->MEM register outputs
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic [31:0]       alu_res_in,
    input  logic [31:0]       val_rm_in,
    input  logic [3:0]        dest_in,
    // Pipeline stall
    output logic              freeze,
    // MEM->WB register
    output logic              wb_en_out,
    output logic              mem_r_en_out,
    output logic [31:0]       alu_res_out,
    output logic [31:0]       mem_data_out,
    output logic [3:0]        dest_out,
    // SRAM interface
    output logic [MEM_AW-1:0] sram_addr,
    output logic [31:0]       sram_dq_out,
    input  logic [31:0]       sram_dq_in,
    output logic              sram_ce_n,
    output logic              sram_we_n,
    output logic              sram_oe_n
);

    // The counter only has to hold WAIT_CYCLES-1.
    localparam int                 c_CNT_W     = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD  = c_CNT_W'(WAIT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [31:0]        c_ADDR_BASE = 32'(ADDR_BASE);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic                w_req;
    logic [31:0]         w_addr_off;
    logic                w_unused_addr;

    logic                r_is_read;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [MEM_AW-1:0]   r_sram_addr;
    logic [31:0]         r_sram_dq_out;
    logic [31:0]         r_read_buf;

    logic                r_wb_en;
    logic                r_mem_r_en;
    logic [31:0]         r_alu_res;
    logic [31:0]         r_mem_data;
    logic [3:0]          r_dest;

    // Any memory operation needs the SRAM; plain ALU results bypass it.
    assign w_req = mem_r_en_in | mem_w_en_in;

    // Byte offset into the SRAM window. The word address is bits [MEM_AW+1:2],
    // so the byte lane and anything above the window are dropped (wrap).
    assign w_addr_off    = alu_res_in - c_ADDR_BASE;
    assign w_unused_addr = ^w_addr_off;

    // State register; reset aborts an access at once so the strobes drop
    // in the same cycle rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic plus freeze and strobe decode.
    always_comb begin
        w_state_next = r_state;
        freeze       = 1'b0;
        sram_ce_n    = 1'b1;
        sram_we_n    = 1'b1;
        sram_oe_n    = 1'b1;
        case (r_state)
            S_IDLE: begin
                // freeze is gated by IDLE: in DONE the inputs still carry the
                // frozen instruction and must not re-raise the stall.
                freeze = w_req & ~rst;
                if (w_req) begin
                    w_state_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                freeze    = ~rst;
                sram_ce_n = 1'b0;
                sram_we_n = r_is_read;
                sram_oe_n = ~r_is_read;
                if (r_cnt == '0) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Access bookkeeping: capture the request in IDLE, count the wait
    // cycles in ACCESS and latch read data on the final one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_is_read     <= 1'b0;
            r_cnt         <= '0;
            r_sram_addr   <= '0;
            r_sram_dq_out <= '0;
            r_read_buf    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        // Read wins if both enables are set.
                        r_is_read     <= mem_r_en_in;
                        r_sram_addr   <= w_addr_off[MEM_AW+1:2];
                        r_sram_dq_out <= val_rm_in;
                        r_cnt         <= c_CNT_LOAD;
                    end
                end
                S_ACCESS: begin
                    if (r_cnt == '0) begin
                        if (r_is_read) begin
                            r_read_buf <= sram_dq_in;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // MEM->WB register: bubbles while frozen, otherwise takes the instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_en    <= 1'b0;
            r_mem_r_en <= 1'b0;
            r_alu_res  <= '0;
            r_mem_data <= '0;
            r_dest     <= '0;
        end else begin
            if (freeze) begin
                r_wb_en    <= 1'b0;
                r_mem_r_en <= 1'b0;
            end else begin
                r_wb_en    <= wb_en_in;
                r_mem_r_en <= mem_r_en_in;
                r_alu_res  <= alu_res_in;
                r_dest     <= dest_in;
            end
            r_mem_data <= ((r_state == S_DONE) && r_is_read) ? r_read_buf : 32'h0;
        end
    end

    assign sram_addr    = r_sram_addr;
    assign sram_dq_out  = r_sram_dq_out;
    assign wb_en_out    = r_wb_en;
    assign mem_r_en_out = r_mem_r_en;
    assign alu_res_out  = r_alu_res;
    assign mem_data_out = r_mem_data;
    assign dest_out     = r_dest;

endmodule
`default_nettype wire
